// File: rtl/dsp_pkg.sv
// Shared DSP definitions: default sample width, audio sample type and the
// state encoding of the serial square-root engine.
package dsp_pkg;

   localparam int DSP_DW = 16;

   typedef logic signed [DSP_DW-1:0] sample_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_ITER = 2'd2,
      ST_OUT  = 2'd3
   } sqrt_state_e;

endpackage

// File: rtl/int_sqrt_serial.sv
// Bit-serial restoring integer square root: 2*DW-bit radicand, DW-bit root,
// one root bit per cycle, DW+2 cycles from start to done (LOAD, DW x ITER, OUT).
module int_sqrt_serial
   import dsp_pkg::*;
#(
   parameter int DW = DSP_DW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [2*DW-1:0] radicand_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [DW-1:0]   root_o
);

   localparam int CW = $clog2(DW);
   localparam int RW = DW + 4;

   sqrt_state_e     state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2*DW-1:0] rad_q, rad_d;
   logic [DW-1:0]   root_q, root_d;
   logic [RW-1:0]   rem_q, rem_d;
   logic [RW-1:0]   remShift, trial;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rad_d    = rad_q;
      root_d   = root_q;
      rem_d    = rem_q;
      remShift = (rem_q << 2) | RW'(rad_q[2*DW-1 -: 2]);
      trial    = {2'b00, root_q, 2'b01};

      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            rad_d   = radicand_i;
            root_d  = '0;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = ST_ITER;
         end
         ST_ITER: begin
            // Bring down the next two radicand bits and try 4*root+1.
            rad_d = rad_q << 2;
            if (remShift >= trial) begin
               rem_d  = remShift - trial;
               root_d = {root_q[DW-2:0], 1'b1};
            end else begin
               rem_d  = remShift;
               root_d = {root_q[DW-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DW - 1)) state_d = ST_OUT;
         end
         ST_OUT: begin
            state_d = start_i ? ST_LOAD : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rad_q   <= '0;
         root_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rad_q   <= rad_d;
         root_q  <= root_d;
         rem_q   <= rem_d;
      end
   end

   assign busy_o = (state_q != ST_IDLE);
   assign done_o = (state_q == ST_OUT);
   assign root_o = root_q;

endmodule

// File: rtl/dsp_rms_meter_mc.sv
// Multi-channel windowed RMS meter sharing one serial sqrt engine.
// Optional per-window peak output enabled by macro DSP_RMS_PEAK_HOLD_EN.
module dsp_rms_meter_mc
   import dsp_pkg::*;
#(
   parameter int DW       = DSP_DW,
   parameter int CH       = 2,
   parameter int CHW      = 1,
   parameter int WIN_LOG2 = 10
) (
   input  logic                  iCLK,
   input  logic                  iRST_N,
   input  logic                  iValid,
   input  logic [CHW-1:0]        iCh,
   input  logic signed [DW-1:0]  iIn,
   input  logic                  iClr,
   output logic                  oValid,
   output logic [CHW-1:0]        oCh,
   output logic [DW-1:0]         oRms,
   output logic                  oBusy,
   output logic                  oOvr
`ifdef DSP_RMS_PEAK_HOLD_EN
   ,
   output logic [DW-1:0]         oPeak
`endif
);

   localparam int MW = 2 * DW;
   localparam int AW = MW + WIN_LOG2;
   localparam int FW = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
   localparam logic [FW-1:0]  FRAME_LAST = FW'((1 << WIN_LOG2) - 1);
   localparam logic [CHW-1:0] CH_LAST    = CHW'(CH - 1);

   logic [AW-1:0]  acc_q [CH];
   logic [AW-1:0]  acc_d [CH];
   logic [AW-1:0]  accSum [CH];
   logic [MW-1:0]  mean_q [CH];
   logic [MW-1:0]  mean_d [CH];
   logic [FW-1:0]  frame_q, frame_d;
   logic [CHW-1:0] k_q, k_d;
   logic           ovr_q, ovr_d;
   logic           oValid_q;
   logic [CHW-1:0] oCh_q;
   logic [DW-1:0]  oRms_q;

   logic [MW-1:0]  sq;
   logic           accept, lastCh, winClose, loadBank, kLast;
   logic           engStart, engBusy, engDone;
   logic [MW-1:0]  radicand;
   logic [DW-1:0]  engRoot;

   // Sign-extending casts make the product the unsigned square of the sample.
   assign sq       = MW'(iIn) * MW'(iIn);
   assign accept   = iValid && ({1'b0, iCh} < (CHW + 1)'(CH));
   assign lastCh   = (iCh == CH_LAST);
   assign winClose = accept && lastCh && (frame_q == FRAME_LAST) && !iClr;
   assign loadBank = winClose && !engBusy;
   assign kLast    = (k_q == CH_LAST);
   assign engStart = loadBank || (engDone && !kLast);

   always_comb begin
      for (int k = 0; k < CH; k++) begin
         accSum[k] = acc_q[k];
         if (accept && (iCh == CHW'(k))) accSum[k] = acc_q[k] + AW'(sq);
         acc_d[k]  = (iClr || winClose) ? '0 : accSum[k];
         mean_d[k] = loadBank ? MW'(accSum[k] >> WIN_LOG2) : mean_q[k];
      end
   end

   always_comb begin
      frame_d = frame_q;
      if (iClr || winClose)    frame_d = '0;
      else if (accept && lastCh) frame_d = frame_q + FW'(1);

      ovr_d = ovr_q;
      if (iClr)                       ovr_d = 1'b0;
      else if (winClose && engBusy)   ovr_d = 1'b1;

      k_d = k_q;
      if (loadBank)     k_d = '0;
      else if (engDone) k_d = kLast ? '0 : k_q + CHW'(1);

      radicand = '0;
      for (int k = 0; k < CH; k++) begin
         if (k_q == CHW'(k)) radicand = mean_q[k];
      end
   end

   int_sqrt_serial #(.DW(DW)) uSqrt (
      .clk        (iCLK),
      .rst_n      (iRST_N),
      .start_i    (engStart),
      .radicand_i (radicand),
      .busy_o     (engBusy),
      .done_o     (engDone),
      .root_o     (engRoot)
   );

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int k = 0; k < CH; k++) begin
            acc_q[k]  <= '0;
            mean_q[k] <= '0;
         end
         frame_q  <= '0;
         k_q      <= '0;
         ovr_q    <= 1'b0;
         oValid_q <= 1'b0;
         oCh_q    <= '0;
         oRms_q   <= '0;
      end else begin
         for (int k = 0; k < CH; k++) begin
            acc_q[k]  <= acc_d[k];
            mean_q[k] <= mean_d[k];
         end
         frame_q  <= frame_d;
         k_q      <= k_d;
         ovr_q    <= ovr_d;
         oValid_q <= engDone;
         if (engDone) begin
            oCh_q  <= k_q;
            oRms_q <= engRoot;
         end
      end
   end

`ifdef DSP_RMS_PEAK_HOLD_EN
   logic [DW-1:0] peak_q [CH];
   logic [DW-1:0] peak_d [CH];
   logic [DW-1:0] peakNew [CH];
   logic [DW-1:0] peakBank_q [CH];
   logic [DW-1:0] peakBank_d [CH];
   logic [DW-1:0] absIn, peakSel;
   logic [DW-1:0] oPeak_q;

   // Two's-complement negation of the most negative sample yields 2^(DW-1) unsigned.
   assign absIn = iIn[DW-1] ? DW'(-iIn) : DW'(iIn);

   always_comb begin
      peakSel = '0;
      for (int k = 0; k < CH; k++) begin
         peakNew[k] = peak_q[k];
         if (accept && (iCh == CHW'(k)) && (absIn > peak_q[k])) peakNew[k] = absIn;
         peak_d[k]     = (iClr || winClose) ? '0 : peakNew[k];
         peakBank_d[k] = loadBank ? peakNew[k] : peakBank_q[k];
         if (k_q == CHW'(k)) peakSel = peakBank_q[k];
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int k = 0; k < CH; k++) begin
            peak_q[k]     <= '0;
            peakBank_q[k] <= '0;
         end
         oPeak_q <= '0;
      end else begin
         for (int k = 0; k < CH; k++) begin
            peak_q[k]     <= peak_d[k];
            peakBank_q[k] <= peakBank_d[k];
         end
         if (engDone) oPeak_q <= peakSel;
      end
   end

   assign oPeak = oPeak_q;
`endif

   assign oValid = oValid_q;
   assign oCh    = oCh_q;
   assign oRms   = oRms_q;
   assign oBusy  = engBusy;
   assign oOvr   = ovr_q;

endmodule

// File: doc/dsp_rms_meter_mc.md
Name: dsp_rms_meter_mc

Overview:
- Multi-channel, windowed RMS meter for the audio effector/visualisation path.
- Accepts interleaved signed audio samples tagged with a channel index.
- Per channel, accumulates squares over a window of 2^WIN_LOG2 frames, then produces floor(sqrt(mean square)).
- A single shared bit-serial square-root engine serves all channels in turn.
- Feeds level meters and the visualiser; successor to the single-channel power/SRC meter, adding channel count, window/width parameters, handshake and overrun reporting.

Parameters:
- DW, 16, sample width (signed input, unsigned RMS output).
- CH, 2, number of channels (1..8).
- CHW, 1, width of the channel index (≥ clog2(CH), min 1).
- WIN_LOG2, 10, window length = 2^WIN_LOG2 frames per channel.

Ports:
- iCLK, in, 1: single clock, all logic on posedge.
- iRST_N, in, 1: asynchronous active-low reset.
- iValid, in, 1: sample strobe, one sample per cycle max.
- iCh, in, CHW: channel of the current sample.
- iIn, in, DW: signed sample.
- iClr, in, 1: synchronous clear of accumulators/window count; the engine is not aborted.
- oValid, out, 1: one-cycle pulse, oRms/oCh valid.
- oCh, out, CHW: channel of oRms.
- oRms, out, DW: unsigned floor(sqrt(mean square)).
- oBusy, out, 1: sqrt engine active.
- oOvr, out, 1: sticky overrun flag, cleared by iClr or reset.

Behaviour:
- Reset: all outputs 0; accumulators, frame counter and engine state 0; engine in IDLE.
- Accept rule: a sample is accepted when iValid=1 and iCh<CH. Samples with iCh≥CH are ignored entirely.
- Accumulate: acc[iCh] += iIn*iIn, with the square computed at 2*DW bits, unsigned. Accumulator width is 2*DW+WIN_LOG2, so it never overflows.
- Frame count: an accepted sample with iCh==CH-1 increments the frame counter (WIN_LOG2 bits, wraps).
- Window close: occurs on an accepted CH-1 sample when the counter equals 2^WIN_LOG2-1. On the same edge:
  - mean[k] = (acc[k] incl. this sample) >> WIN_LOG2, for all k, latched into a 2*DW-bit holding bank.
  - All accumulators reset to 0.
  - The counter wraps to 0.
- Engine FSM states: IDLE, LOAD, ITER, OUT.
  - IDLE: leaves on window close if not busy; k=0.
  - LOAD (1 cycle): radicand = mean[k], root=0, remainder=0.
  - ITER (DW cycles): restoring sqrt, one result bit per cycle, MSB first.
  - OUT (1 cycle): oValid=1, oCh=k, oRms=root. Then k++; return to LOAD if k<CH, else IDLE.
- Latency: with the closing sample on edge N, oValid for channel k is high in the cycle after edge N+(k+1)*(DW+2). Pulses are spaced DW+2 cycles apart in ascending k.
- oRms/oCh hold their value between pulses.
- oBusy=1 in LOAD/ITER/OUT.
- Overrun: if a window closes while oBusy=1, the new means are discarded. The engine continues undisturbed, oOvr sets, and accumulators still clear.
- Simultaneous iClr and accepted sample: iClr wins; the sample is dropped and the counter goes to 0. iClr during a window-close edge suppresses the close.
- Full-scale: -2^(DW-1) squared gives mean 2^(2DW-2) and oRms = 2^(DW-1) (16'h8000). The output is unsigned, so this is legal.
- Reset mid-operation: engine aborts to IDLE, no oValid is emitted, all state is cleared.

Optional Feature:
- Macro: DSP_RMS_PEAK_HOLD_EN.
- Defined: adds an output oPeak [DW-1:0], the per-window max |iIn| of channel oCh, presented with oValid. |−2^(DW-1)| = 2^(DW-1). Peaks are latched alongside the means at window close and cleared with the accumulators.
- Undefined: no port and no peak registers. Behaviour is otherwise identical.

Decomposition:
- Shared package (dsp_pkg): audio sample typedef (signed DW), DSP_DW=16, and FSM state encodings for IDLE/LOAD/ITER/OUT.
- One sub-module: int_sqrt_serial (radicand 2*DW, root DW, start/done, DW+2 cycles per root). The top instantiates one copy and sequences the channels through it.

Test Plan:
- DW=16, CH=2, WIN_LOG2=3; ch0=100 and ch1=-300 for 8 frames -> pulses oCh=0 oRms=100, then oCh=1 oRms=300, 18 cycles apart, with the first pulse at 18 cycles after the close.
- ch0 alternating +1000/-1000, ch1 all 0 -> oRms 1000 and 0.
- ch0 alternating 1,2 (sum of squares 20, mean 2) -> oRms=1 (floor). ch1 constant -32768 -> oRms=16'h8000.
- WIN_LOG2=0, iValid every cycle -> first window reports, second window closes while busy -> oOvr=1. Pulse spacing stays at 18; iClr then drops oOvr to 0.
- iCh=3 samples interleaved (CH=2) -> ignored, results unchanged. iClr asserted mid-window -> the next report covers only post-clear frames.
- Assert iRST_N=0 during ITER -> all outputs 0 immediately, no oValid. After release, a fresh window reports correctly. With DSP_RMS_PEAK_HOLD_EN, ch0 samples {5,-900,3,...} -> oPeak=900.
